// File: rtl/slave_rx_port_if.sv
// slave_rx_port_if: serial system-bus signals between master_port and a slave
// endpoint. All signals are single-bit and are sampled on the rising clock edge.
interface slave_rx_port_if;
   logic sel;
   logic read_en;
   logic write_en;
   logic m_valid;
   logic addr_bus;
   logic burst_size_bus;
   logic w_data_bus;
   logic s_ready;
   logic s_valid;
   logic rx_data;

   modport master (
      output sel, read_en, write_en, m_valid, addr_bus, burst_size_bus, w_data_bus,
      input  s_ready, s_valid, rx_data
   );

   modport slave (
      input  sel, read_en, write_en, m_valid, addr_bus, burst_size_bus, w_data_bus,
      output s_ready, s_valid, rx_data
   );
endinterface

// File: rtl/slave_rx_port.sv
// slave_rx_port: slave-side endpoint of the serial system bus.
// Deserialises address, burst count and write words sent LSB first, drives a
// parallel memory port, and serialises read words back to the master.
// Optional feature macro: SLAVE_PARITY_EN. When defined, each write word is
// followed by an even-parity bit; a bad word is not written and parity_err
// latches high until reset. When undefined, parity_err is tied low.
module slave_rx_port #(
   parameter int SLAVE_ADDR_SIZE = 12,
   parameter int BURST_SIZE      = 12,
   parameter int WORD_SIZE       = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   slave_rx_port_if.slave             bus,
   output logic [SLAVE_ADDR_SIZE-1:0] mem_addr,
   output logic [WORD_SIZE-1:0]       mem_wdata,
   output logic                       mem_we,
   output logic                       mem_re,
   input  logic [WORD_SIZE-1:0]       mem_rdata,
   output logic                       parity_err
);
   localparam int A = SLAVE_ADDR_SIZE;
   localparam int B = BURST_SIZE;
   localparam int W = WORD_SIZE;
`ifdef SLAVE_PARITY_EN
   localparam int WBITS = W + 1;
`else
   localparam int WBITS = W;
`endif
   localparam int CW = $clog2(A + WBITS + 1);

   localparam logic [CW-1:0] ADDR_LAST  = CW'(A - 1);
   localparam logic [CW-1:0] BURST_BITS = CW'(B);
   localparam logic [CW-1:0] DATA_BITS  = CW'(W);
   localparam logic [CW-1:0] WBIT_LAST  = CW'(WBITS - 1);
   localparam logic [CW-1:0] RBIT_LAST  = CW'(W - 1);

   localparam logic [2:0] IDLE   = 3'd0,
                          ADDR   = 3'd1,
                          WDATA  = 3'd2,
                          WMEM   = 3'd3,
                          RREQ   = 3'd4,
                          RWAIT  = 3'd5,
                          RSHIFT = 3'd6;

   logic [2:0]    state;
   logic          is_read;
   logic [CW-1:0] cnt;
   logic [B-1:0]  k;
   logic [A-1:0]  addr_sh;
   logic [B-1:0]  burst_sh;
   logic [W-1:0]  wd_sh;
   logic [W-1:0]  rd_sh;
   logic [B-1:0]  burst_last;
   logic          last_word;
   logic          start;
`ifdef SLAVE_PARITY_EN
   logic          par_bad;
`endif

   // A burst field of zero still moves one word, so the last index is clamped at 0.
   assign burst_last = (burst_sh == '0) ? '0 : burst_sh - 1'b1;
   assign last_word  = (k == burst_last);
   assign start      = bus.sel && bus.m_valid && (bus.read_en ^ bus.write_en);

   // Main transaction sequencer: address/burst capture, write assembly, read serialisation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         is_read  <= 1'b0;
         cnt      <= '0;
         k        <= '0;
         addr_sh  <= '0;
         burst_sh <= '0;
         wd_sh    <= '0;
         rd_sh    <= '0;
`ifdef SLAVE_PARITY_EN
         par_bad    <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  is_read  <= bus.read_en;
                  addr_sh  <= (addr_sh >> 1) | (A'(bus.addr_bus) << (A - 1));
                  burst_sh <= (burst_sh >> 1) | (B'(bus.burst_size_bus) << (B - 1));
                  cnt      <= CW'(1);
                  k        <= '0;
                  state    <= ADDR;
               end
            end
            ADDR: begin
               if (!bus.m_valid) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  addr_sh <= (addr_sh >> 1) | (A'(bus.addr_bus) << (A - 1));
                  if (cnt < BURST_BITS) begin
                     burst_sh <= (burst_sh >> 1) | (B'(bus.burst_size_bus) << (B - 1));
                  end
                  if (cnt == ADDR_LAST) begin
                     cnt   <= '0;
                     state <= is_read ? RREQ : WDATA;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            WDATA: begin
               if (bus.m_valid) begin
                  if (cnt < DATA_BITS) begin
                     wd_sh <= (wd_sh >> 1) | (W'(bus.w_data_bus) << (W - 1));
                  end
`ifdef SLAVE_PARITY_EN
                  else begin
                     par_bad <= (bus.w_data_bus != ^wd_sh);
                     if (bus.w_data_bus != ^wd_sh) begin
                        parity_err <= 1'b1;
                     end
                  end
`endif
                  if (cnt == WBIT_LAST) begin
                     cnt   <= '0;
                     state <= WMEM;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end else if (cnt != '0) begin
                  cnt   <= '0;
                  state <= IDLE;
               end
            end
            WMEM: begin
               k     <= k + 1'b1;
               state <= last_word ? IDLE : WDATA;
            end
            RREQ: begin
               state <= RWAIT;
            end
            RWAIT: begin
               rd_sh <= mem_rdata;
               cnt   <= '0;
               state <= RSHIFT;
            end
            RSHIFT: begin
               rd_sh <= rd_sh >> 1;
               if (cnt == RBIT_LAST) begin
                  cnt   <= '0;
                  k     <= k + 1'b1;
                  state <= last_word ? IDLE : RREQ;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.s_ready = (state == IDLE);
   assign bus.s_valid = (state == RSHIFT);
   assign bus.rx_data = (state == RSHIFT) && rd_sh[0];
   assign mem_addr    = addr_sh + A'(k);
   assign mem_wdata   = wd_sh;
   assign mem_re      = (state == RREQ);
`ifdef SLAVE_PARITY_EN
   assign mem_we      = (state == WMEM) && !par_bad;
`else
   assign mem_we      = (state == WMEM);
   assign parity_err  = 1'b0;
`endif
endmodule

// File: tb/tb_slave_rx_port.sv
// tb_slave_rx_port: table-driven directed vectors, hand-written corner
// sequences and a randomized run against a transaction-level memory model.
// Honours SLAVE_PARITY_EN in the same way as the design.
module tb_slave_rx_port;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic [7:0]  mem_rdata = 8'h00;
   logic        parity_err;

   slave_rx_port_if bus();

   slave_rx_port dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_re     (mem_re),
      .mem_rdata  (mem_rdata),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rd;
      logic [11:0] addr;
      logic [11:0] burst;
      logic [7:0]  d0;
      logic [7:0]  d1;
      int          nWe;
      int          nRe;
      logic [11:0] a0;
      logic [11:0] a1;
      logic [7:0]  x0;
      logic [7:0]  x1;
   } vec_t;

   int          nVec = 0;
   int          nErr = 0;
   logic [7:0]  txData [0:15];
   logic [7:0]  refMem [0:4095];
   logic [7:0]  tbMem  [0:4095];
   bit          memReady;
   logic        preloadEn = 1'b0;
   logic [11:0] preloadAddr = '0;
   logic [7:0]  preloadData = '0;
   logic        expPerr = 1'b0;

   logic [19:0] weQ[$];
   logic [11:0] reQ[$];
   logic        bitQ[$];
   logic        svLog[$];
   logic [19:0] expWe[$];
   logic [11:0] expRe[$];
   logic [7:0]  expWords[$];

   function automatic logic [7:0] memInit(input logic [11:0] a);
      return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'hA5;
   endfunction

   // Memory behind the slave: read data appears the cycle after mem_re.
   always @(posedge clk) begin
      if (!memReady) begin
         for (int i = 0; i < 4096; i++) tbMem[i] <= memInit(12'(i));
         memReady <= 1'b1;
      end else begin
         if (preloadEn) tbMem[preloadAddr] <= preloadData;
         if (mem_we) tbMem[mem_addr] <= mem_wdata;
         if (mem_re) mem_rdata <= tbMem[mem_addr];
      end
   end

   // Event monitor sampled mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (mem_we) weQ.push_back({mem_addr, mem_wdata});
      if (mem_re) reQ.push_back(mem_addr);
      if (bus.s_valid) bitQ.push_back(bus.rx_data);
      if (!bus.s_ready) svLog.push_back(bus.s_valid);
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nVec++;
      if (actual !== expected) begin
         nErr++;
         $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
      end
   endtask

   function automatic logic [7:0] rxWord(input int k);
      logic [7:0] w = '0;
      for (int i = 0; i < 8; i++) if (8 * k + i < bitQ.size()) w[i] = bitQ[8 * k + i];
      return w;
   endfunction

   task automatic busIdle();
      bus.sel = 1'b0; bus.read_en = 1'b0; bus.write_en = 1'b0; bus.m_valid = 1'b0;
      bus.addr_bus = 1'b0; bus.burst_size_bus = 1'b0; bus.w_data_bus = 1'b0;
   endtask

   task automatic preload(input logic [11:0] a, input logic [7:0] d);
      @(negedge clk);
      preloadEn = 1'b1; preloadAddr = a; preloadData = d;
      refMem[a] = d;
      @(negedge clk);
      preloadEn = 1'b0;
   endtask

   task automatic sendAddr(input bit rd, input logic [11:0] addr, input logic [11:0] burst);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         bus.sel = (i == 0);
         bus.m_valid = 1'b1; bus.read_en = rd; bus.write_en = !rd;
         bus.addr_bus = addr[i]; bus.burst_size_bus = burst[i];
      end
   endtask

   task automatic sendWord(input logic [7:0] d, input bit bad);
      for (int b = 0; b < 8; b++) begin
         @(negedge clk);
         bus.m_valid = 1'b1; bus.w_data_bus = d[b];
      end
`ifdef SLAVE_PARITY_EN
      @(negedge clk);
      bus.w_data_bus = (^d) ^ bad;
`endif
      @(negedge clk);
      bus.m_valid = 1'b0; bus.w_data_bus = 1'b0;
   endtask

   task automatic waitIdle(input int budget);
      int n = 0;
      while (!bus.s_ready && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput("return_to_idle", 32'(bus.s_ready), 1);
   endtask

   task automatic applyStimulus(input bit rd, input logic [11:0] addr, input logic [11:0] burst,
                                input int n, input logic [15:0] badMask);
      weQ.delete(); reQ.delete(); bitQ.delete(); svLog.delete();
      sendAddr(rd, addr, burst);
      if (rd) begin
         @(negedge clk);
         busIdle();
      end else begin
         for (int w = 0; w < n; w++) begin
            sendWord(txData[w], badMask[w]);
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      end
      busIdle();
      waitIdle(400);
   endtask

   vec_t        vecs [0:4];
   bit          rd;
   logic [11:0] addr, burst, a;
   logic [15:0] bad;
   int          n, ones, rises;

   initial begin
      busIdle();
      for (int i = 0; i < 4096; i++) refMem[i] = memInit(12'(i));

      vecs[0] = '{1'b0, 12'h005, 12'd1, 8'hA9, 8'h00, 1, 0, 12'h005, 12'h000, 8'hA9, 8'h00};
      vecs[1] = '{1'b1, 12'h2B5, 12'd2, 8'h3C, 8'hC3, 0, 2, 12'h2B5, 12'h2B6, 8'h3C, 8'hC3};
      vecs[2] = '{1'b0, 12'hFFF, 12'd2, 8'h11, 8'h22, 2, 0, 12'hFFF, 12'h000, 8'h11, 8'h22};
      vecs[3] = '{1'b0, 12'h123, 12'd0, 8'h5A, 8'h00, 1, 0, 12'h123, 12'h000, 8'h5A, 8'h00};
      vecs[4] = '{1'b1, 12'hFFF, 12'd2, 8'h77, 8'h88, 0, 2, 12'hFFF, 12'h000, 8'h77, 8'h88};

      // Reset state
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("rst_s_ready", 32'(bus.s_ready), 1);
      checkOutput("rst_s_valid", 32'(bus.s_valid), 0);
      checkOutput("rst_rx_data", 32'(bus.rx_data), 0);
      checkOutput("rst_mem_we", 32'(mem_we), 0);
      checkOutput("rst_mem_re", 32'(mem_re), 0);
      checkOutput("rst_mem_addr", 32'(mem_addr), 0);
      checkOutput("rst_mem_wdata", 32'(mem_wdata), 0);
      checkOutput("rst_parity_err", 32'(parity_err), 0);
      rst = 1'b0;

      // Directed vector table
      for (int v = 0; v < 5; v++) begin
         n = (vecs[v].burst == 0) ? 1 : int'(vecs[v].burst);
         if (vecs[v].rd) begin
            preload(vecs[v].addr, vecs[v].d0);
            preload(vecs[v].addr + 12'd1, vecs[v].d1);
         end else begin
            txData[0] = vecs[v].d0;
            txData[1] = vecs[v].d1;
            if (vecs[v].nWe > 0) refMem[vecs[v].a0] = vecs[v].x0;
            if (vecs[v].nWe > 1) refMem[vecs[v].a1] = vecs[v].x1;
         end
         applyStimulus(vecs[v].rd, vecs[v].addr, vecs[v].burst, n, 16'h0);
         checkOutput($sformatf("vec%0d_we_count", v), 32'(weQ.size()), 32'(vecs[v].nWe));
         checkOutput($sformatf("vec%0d_re_count", v), 32'(reQ.size()), 32'(vecs[v].nRe));
         if (vecs[v].nWe > 0 && weQ.size() > 0)
            checkOutput($sformatf("vec%0d_we0", v), 32'(weQ[0]), 32'({vecs[v].a0, vecs[v].x0}));
         if (vecs[v].nWe > 1 && weQ.size() > 1)
            checkOutput($sformatf("vec%0d_we1", v), 32'(weQ[1]), 32'({vecs[v].a1, vecs[v].x1}));
         if (vecs[v].nRe > 0) begin
            checkOutput($sformatf("vec%0d_rx_bits", v), 32'(bitQ.size()), 32'(8 * vecs[v].nRe));
            if (reQ.size() > 0) checkOutput($sformatf("vec%0d_re0", v), 32'(reQ[0]), 32'(vecs[v].a0));
            checkOutput($sformatf("vec%0d_rx0", v), 32'(rxWord(0)), 32'(vecs[v].x0));
         end
         if (vecs[v].nRe > 1) begin
            if (reQ.size() > 1) checkOutput($sformatf("vec%0d_re1", v), 32'(reQ[1]), 32'(vecs[v].a1));
            checkOutput($sformatf("vec%0d_rx1", v), 32'(rxWord(1)), 32'(vecs[v].x1));
            ones = 0; rises = 0;
            for (int i = 0; i < svLog.size(); i++) begin
               if (svLog[i]) ones++;
               if (svLog[i] && (i == 0 || !svLog[i-1])) rises++;
            end
            checkOutput($sformatf("vec%0d_busy_cycles", v), 32'(svLog.size()), 32'(11 + 10 * vecs[v].nRe));
            checkOutput($sformatf("vec%0d_s_valid_cycles", v), 32'(ones), 32'(8 * vecs[v].nRe));
            checkOutput($sformatf("vec%0d_s_valid_bursts", v), 32'(rises), 32'(vecs[v].nRe));
         end
      end

      // Both or neither direction request, and sel low: request ignored
      weQ.delete(); reQ.delete();
      @(negedge clk);
      bus.sel = 1'b1; bus.m_valid = 1'b1; bus.read_en = 1'b1; bus.write_en = 1'b1;
      bus.addr_bus = 1'b1; bus.burst_size_bus = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput($sformatf("both_en_ready%0d", i), 32'(bus.s_ready), 1);
      end
      bus.read_en = 1'b0; bus.write_en = 1'b0;
      @(negedge clk);
      checkOutput("no_en_ready", 32'(bus.s_ready), 1);
      bus.sel = 1'b0; bus.read_en = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("sel_low_ready", 32'(bus.s_ready), 1);
      busIdle();
      @(negedge clk);
      checkOutput("ignored_we_count", 32'(weQ.size()), 0);
      checkOutput("ignored_re_count", 32'(reQ.size()), 0);

      // m_valid gap mid-address aborts
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 1) checkOutput("busy_after_start", 32'(bus.s_ready), 0);
         bus.sel = (i == 0); bus.m_valid = 1'b1; bus.write_en = 1'b1; bus.addr_bus = 1'b1;
      end
      @(negedge clk);
      busIdle();
      @(negedge clk);
      checkOutput("addr_abort_ready", 32'(bus.s_ready), 1);

      // m_valid gap after 4 data bits aborts with no write
      weQ.delete();
      sendAddr(1'b0, 12'h100, 12'd1);
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         bus.m_valid = 1'b1; bus.w_data_bus = 1'b1;
      end
      @(negedge clk);
      busIdle();
      @(negedge clk);
      checkOutput("wdata_abort_ready", 32'(bus.s_ready), 1);
      repeat (3) @(negedge clk);
      checkOutput("wdata_abort_we_count", 32'(weQ.size()), 0);

      // Parity handling
      txData[0] = 8'hA9;
`ifdef SLAVE_PARITY_EN
      applyStimulus(1'b0, 12'h0AB, 12'd1, 1, 16'h1);
      expPerr = 1'b1;
      checkOutput("bad_parity_we_count", 32'(weQ.size()), 0);
`else
      applyStimulus(1'b0, 12'h0AB, 12'd1, 1, 16'h0);
      refMem[12'h0AB] = 8'hA9;
      checkOutput("plain_we_count", 32'(weQ.size()), 1);
`endif
      checkOutput("parity_err_after_word", 32'(parity_err), 32'(expPerr));
      txData[0] = 8'h5C;
      refMem[12'h0AC] = 8'h5C;
      applyStimulus(1'b0, 12'h0AC, 12'd1, 1, 16'h0);
      checkOutput("good_word_we_count", 32'(weQ.size()), 1);
      if (weQ.size() > 0) checkOutput("good_word_we", 32'(weQ[0]), 32'({12'h0AC, 8'h5C}));
      checkOutput("parity_err_sticky", 32'(parity_err), 32'(expPerr));

      // Synchronous reset during bit 5 of a write word
      weQ.delete();
      sendAddr(1'b0, 12'h0C0, 12'd1);
      for (int b = 0; b < 5; b++) begin
         @(negedge clk);
         bus.m_valid = 1'b1; bus.w_data_bus = 1'b1;
      end
      @(negedge clk);
      bus.w_data_bus = 1'b1; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      busIdle();
      expPerr = 1'b0;
      checkOutput("midrst_s_ready", 32'(bus.s_ready), 1);
      checkOutput("midrst_s_valid", 32'(bus.s_valid), 0);
      checkOutput("midrst_mem_addr", 32'(mem_addr), 0);
      checkOutput("midrst_mem_wdata", 32'(mem_wdata), 0);
      checkOutput("midrst_parity_err", 32'(parity_err), 0);
      repeat (12) @(negedge clk);
      checkOutput("midrst_we_count", 32'(weQ.size()), 0);

      // Randomized transactions against the memory model
      for (int t = 0; t < 30; t++) begin
         rd = 1'($urandom_range(0, 1));
         addr = ($urandom_range(0, 3) == 0) ? 12'hFFE + 12'($urandom_range(0, 1)) : 12'($urandom);
         burst = 12'($urandom_range(0, 4));
         n = (burst == 0) ? 1 : int'(burst);
         bad = '0;
         for (int w = 0; w < n; w++) begin
            txData[w] = 8'($urandom);
`ifdef SLAVE_PARITY_EN
            bad[w] = ($urandom_range(0, 5) == 0);
`endif
         end
         expWe.delete(); expRe.delete(); expWords.delete();
         for (int k = 0; k < n; k++) begin
            a = addr + 12'(k);
            if (rd) begin
               expRe.push_back(a);
               expWords.push_back(refMem[a]);
            end else if (!bad[k]) begin
               expWe.push_back({a, txData[k]});
               refMem[a] = txData[k];
            end else begin
               expPerr = 1'b1;
            end
         end
         applyStimulus(rd, addr, burst, n, bad);
         checkOutput($sformatf("rnd%0d_we_count", t), 32'(weQ.size()), 32'(expWe.size()));
         for (int i = 0; i < expWe.size() && i < weQ.size(); i++)
            checkOutput($sformatf("rnd%0d_we%0d", t, i), 32'(weQ[i]), 32'(expWe[i]));
         checkOutput($sformatf("rnd%0d_re_count", t), 32'(reQ.size()), 32'(expRe.size()));
         for (int i = 0; i < expRe.size() && i < reQ.size(); i++)
            checkOutput($sformatf("rnd%0d_re%0d", t, i), 32'(reQ[i]), 32'(expRe[i]));
         checkOutput($sformatf("rnd%0d_rx_bits", t), 32'(bitQ.size()), 32'(8 * expWords.size()));
         for (int i = 0; i < expWords.size(); i++)
            checkOutput($sformatf("rnd%0d_rx%0d", t, i), 32'(rxWord(i)), 32'(expWords[i]));
         checkOutput($sformatf("rnd%0d_parity_err", t), 32'(parity_err), 32'(expPerr));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end
endmodule
